// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the RV32I multicycle control unit: opcodes, ALU ops,
// writeback-source selects, FSM states and the decoded-control bundle.
package multicycle_control_unit_pkg;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_L  = 7'b0000011;
  localparam logic [6:0] OP_S  = 7'b0100011;
  localparam logic [6:0] OP_B  = 7'b1100011;
  localparam logic [6:0] OP_LU = 7'b0110111;
  localparam logic [6:0] OP_AU = 7'b0010111;
  localparam logic [6:0] OP_J  = 7'b1101111;
  localparam logic [6:0] OP_JL = 7'b1100111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  localparam logic [2:0] RFWD_ALU   = 3'd0;
  localparam logic [2:0] RFWD_LOAD  = 3'd1;
  localparam logic [2:0] RFWD_IMM   = 3'd2;
  localparam logic [2:0] RFWD_PCIMM = 3'd3;
  localparam logic [2:0] RFWD_PC4   = 3'd4;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXECUTE = 4'd2,
    S_MEM     = 4'd3,
    S_WB      = 4'd4,
    S_BR_DONE = 4'd5,
    S_LD_WB   = 4'd6
  } state_e;

  typedef struct packed {
    logic [3:0] alu_ctrl;
    logic       alu_src;
    logic [2:0] rfwd_sel;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic       is_load;
    logic       is_store;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/multicycle_control_unit_decoder.sv
// Combinational instruction-word to datapath-control mapping; the FSM in the
// top level decides when these controls take effect.
module cu_decoder
  import multicycle_control_unit_pkg::*;
(
  input  logic [31:0] instr_i,
  output dec_t        dec_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic       unused_instr_bits;

  assign opcode            = instr_i[6:0];
  assign funct3            = instr_i[14:12];
  assign funct7_b5         = instr_i[30];
  assign unused_instr_bits = ^{instr_i[31], instr_i[29:15], instr_i[11:7]};

  always_comb begin
    dec_o          = '0;
    dec_o.alu_ctrl = ALU_ADD;
    dec_o.rfwd_sel = RFWD_ALU;
    case (opcode)
      OP_R: dec_o.alu_ctrl = {funct7_b5, funct3};
      OP_I: begin
        // Only the shift-right pair uses funct7[5] to pick SRA over SRL.
        dec_o.alu_ctrl = {(funct3 == 3'b101) & funct7_b5, funct3};
        dec_o.alu_src  = 1'b1;
      end
      OP_L: begin
        dec_o.alu_src  = 1'b1;
        dec_o.rfwd_sel = RFWD_LOAD;
        dec_o.is_load  = 1'b1;
      end
      OP_S: begin
        dec_o.alu_src  = 1'b1;
        dec_o.is_store = 1'b1;
      end
      OP_B: begin
        dec_o.alu_ctrl = {1'b0, funct3};
        dec_o.branch   = 1'b1;
      end
      OP_LU: dec_o.rfwd_sel = RFWD_IMM;
      OP_AU: dec_o.rfwd_sel = RFWD_PCIMM;
      OP_J: begin
        dec_o.jal      = 1'b1;
        dec_o.rfwd_sel = RFWD_PC4;
      end
      OP_JL: begin
        dec_o.jal      = 1'b1;
        dec_o.jalr     = 1'b1;
        dec_o.alu_src  = 1'b1;
        dec_o.rfwd_sel = RFWD_PC4;
      end
      default: dec_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// RV32I multicycle control FSM: sequences FETCH..WB, owns the data-bus
// request/ready handshake and its timeout.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int BUS_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrCode,
  output logic        regFileWe,
  output logic [3:0]  aluControl,
  output logic        aluSrcMuxSel,
  output logic [2:0]  RFWDSrcMuxSel,
  output logic        branch,
  output logic        jal,
  output logic        jalr,
  output logic        PCEn,
  output logic        busReq,
  output logic        busWe,
  output logic [2:0]  busSize,
  input  logic        busReady,
  output logic        busErr,
  output logic        illegal,
  output logic [3:0]  state
);

  localparam int              CNT_W      = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
  localparam bit              TIMEOUT_EN = (BUS_TIMEOUT > 0);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'((BUS_TIMEOUT > 0) ? BUS_TIMEOUT - 1 : 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dec_t             dec;
  logic             timeout;
  logic             we_s, pcen_s, req_s, bwe_s, err_s, ill_s;

  cu_decoder u_dec (
    .instr_i (instrCode),
    .dec_o   (dec)
  );

  assign timeout = TIMEOUT_EN && (cnt_q == CNT_LIMIT) && !busReady;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    we_s    = 1'b0;
    pcen_s  = 1'b0;
    req_s   = 1'b0;
    bwe_s   = 1'b0;
    err_s   = 1'b0;
    ill_s   = 1'b0;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE: begin
        ill_s = dec.illegal;
        if (dec.is_load || dec.is_store) state_d = S_MEM;
        else if (dec.branch || dec.illegal) state_d = S_BR_DONE;
        else state_d = S_WB;
      end
      S_MEM: begin
        req_s = 1'b1;
        bwe_s = dec.is_store;
        // Ready takes priority over a timeout landing in the same cycle.
        if (busReady) begin
          if (dec.is_store) begin
            pcen_s  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_LD_WB;
          end
        end else if (timeout) begin
          err_s   = 1'b1;
          pcen_s  = 1'b1;
          state_d = S_FETCH;
        end else if (TIMEOUT_EN) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WB: begin
        we_s    = !dec.illegal;
        pcen_s  = 1'b1;
        state_d = S_FETCH;
      end
      S_LD_WB: begin
        we_s    = 1'b1;
        pcen_s  = 1'b1;
        state_d = S_FETCH;
      end
      S_BR_DONE: begin
        pcen_s  = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Strobes are also gated by reset so a mid-access reset drops them at once.
  assign regFileWe = we_s   & ~reset;
  assign PCEn      = pcen_s & ~reset;
  assign busReq    = req_s  & ~reset;
  assign busWe     = bwe_s  & ~reset;
  assign busErr    = err_s  & ~reset;
  assign illegal   = ill_s  & ~reset;
  assign busSize   = busReq ? instrCode[14:12] : 3'b000;

  always_comb begin
    aluControl    = ALU_ADD;
    aluSrcMuxSel  = 1'b0;
    RFWDSrcMuxSel = RFWD_ALU;
    branch        = 1'b0;
    jal           = 1'b0;
    jalr          = 1'b0;
    if (state_q != S_FETCH) begin
      aluControl    = dec.alu_ctrl;
      aluSrcMuxSel  = dec.alu_src;
      RFWDSrcMuxSel = dec.rfwd_sel;
      branch        = dec.branch;
      jal           = dec.jal;
      jalr          = dec.jalr;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit with a short bus timeout (4).
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instrCode;
  logic        regFileWe, aluSrcMuxSel, branch, jal, jalr, PCEn;
  logic        busReq, busWe, busReady, busErr, illegal;
  logic [3:0]  aluControl, state;
  logic [2:0]  RFWDSrcMuxSel, busSize;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SRAI = 32'h4032D293;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_LUI  = 32'h123450B7;
  localparam logic [31:0] I_ILL  = 32'h0000007F;
  localparam logic [31:0] I_LW   = 32'h0080A203;
  localparam logic [31:0] I_SW   = 32'h0020A223;
  localparam logic [31:0] I_JALR = 32'h00010067;

  multicycle_control_unit #(.BUS_TIMEOUT(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .instrCode     (instrCode),
    .regFileWe     (regFileWe),
    .aluControl    (aluControl),
    .aluSrcMuxSel  (aluSrcMuxSel),
    .RFWDSrcMuxSel (RFWDSrcMuxSel),
    .branch        (branch),
    .jal           (jal),
    .jalr          (jalr),
    .PCEn          (PCEn),
    .busReq        (busReq),
    .busWe         (busWe),
    .busSize       (busSize),
    .busReady      (busReady),
    .busErr        (busErr),
    .illegal       (illegal),
    .state         (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Strobe vector order: {regFileWe, PCEn, busReq, busWe, busErr, illegal}.
  task automatic ctl(input string tag, input logic [3:0] st, input logic [5:0] str);
    chk({tag, "_state"}, {28'd0, state}, {28'd0, st});
    chk({tag, "_strobes"}, {26'd0, regFileWe, PCEn, busReq, busWe, busErr, illegal},
        {26'd0, str});
  endtask

  // Decoded vector order: {aluControl, aluSrcMuxSel, RFWDSrcMuxSel, branch, jal, jalr}.
  task automatic dchk(input string tag, input logic [10:0] exp);
    chk({tag, "_dec"}, {21'd0, aluControl, aluSrcMuxSel, RFWDSrcMuxSel, branch, jal, jalr},
        {21'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    instrCode = 32'd0;
    busReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    ctl("rst", 4'd0, 6'b000000);
    dchk("rst", 11'd0);
    reset = 1'b0;

    // ADD x3,x1,x2
    instrCode = I_ADD;
    #1;
    ctl("add_f", 4'd0, 6'b000000);
    dchk("add_f", 11'd0);
    tick(); ctl("add_d", 4'd1, 6'b000000); dchk("add_d", {4'b0000, 1'b0, 3'd0, 3'b000});
    tick(); ctl("add_e", 4'd2, 6'b000000);
    tick(); ctl("add_wb", 4'd4, 6'b110000);
    tick(); ctl("add_end", 4'd0, 6'b000000);

    // SRAI x5,x5,3
    instrCode = I_SRAI;
    tick(); ctl("srai_d", 4'd1, 6'b000000); dchk("srai_d", {4'b1101, 1'b1, 3'd0, 3'b000});
    tick(); ctl("srai_e", 4'd2, 6'b000000);
    tick(); ctl("srai_wb", 4'd4, 6'b110000);
    tick(); ctl("srai_end", 4'd0, 6'b000000);

    // BEQ
    instrCode = I_BEQ;
    tick(); ctl("beq_d", 4'd1, 6'b000000); dchk("beq_d", {4'b0000, 1'b0, 3'd0, 3'b100});
    tick(); ctl("beq_e", 4'd2, 6'b000000);
    tick(); ctl("beq_br", 4'd5, 6'b010000); dchk("beq_br", {4'b0000, 1'b0, 3'd0, 3'b100});
    tick(); ctl("beq_end", 4'd0, 6'b000000);

    // LUI
    instrCode = I_LUI;
    tick(); ctl("lui_d", 4'd1, 6'b000000); dchk("lui_d", {4'b0000, 1'b0, 3'd2, 3'b000});
    tick(); ctl("lui_e", 4'd2, 6'b000000);
    tick(); ctl("lui_wb", 4'd4, 6'b110000);
    tick(); ctl("lui_end", 4'd0, 6'b000000);

    // Unknown opcode
    instrCode = I_ILL;
    tick(); ctl("ill_d", 4'd1, 6'b000000);
    tick(); ctl("ill_e", 4'd2, 6'b000001);
    tick(); ctl("ill_br", 4'd5, 6'b010000);
    tick(); ctl("ill_end", 4'd0, 6'b000000);

    // LW x4,8(x1), ready on the third MEM cycle
    instrCode = I_LW;
    tick(); ctl("lw_d", 4'd1, 6'b000000); dchk("lw_d", {4'b0000, 1'b1, 3'd1, 3'b000});
    tick(); ctl("lw_e", 4'd2, 6'b000000);
    tick(); ctl("lw_m1", 4'd3, 6'b001000); chk("lw_m1_size", {29'd0, busSize}, 32'd2);
    tick(); ctl("lw_m2", 4'd3, 6'b001000);
    tick(); busReady = 1'b1; #1;
    ctl("lw_m3", 4'd3, 6'b001000); chk("lw_m3_size", {29'd0, busSize}, 32'd2);
    tick(); busReady = 1'b0; #1;
    ctl("lw_ldwb", 4'd6, 6'b110000); dchk("lw_ldwb", {4'b0000, 1'b1, 3'd1, 3'b000});
    chk("lw_ldwb_size", {29'd0, busSize}, 32'd0);
    tick(); ctl("lw_end", 4'd0, 6'b000000);

    // SW with no ready: timeout on the 4th MEM cycle
    instrCode = I_SW;
    tick(); ctl("swto_d", 4'd1, 6'b000000); dchk("swto_d", {4'b0000, 1'b1, 3'd0, 3'b000});
    tick(); ctl("swto_e", 4'd2, 6'b000000);
    tick(); ctl("swto_m1", 4'd3, 6'b001100);
    tick(); ctl("swto_m2", 4'd3, 6'b001100);
    tick(); ctl("swto_m3", 4'd3, 6'b001100);
    tick(); ctl("swto_m4", 4'd3, 6'b011110);
    tick(); ctl("swto_end", 4'd0, 6'b000000);

    // SW with ready coinciding with the timeout cycle: ready wins
    tick(); ctl("swrdy_d", 4'd1, 6'b000000);
    tick(); ctl("swrdy_e", 4'd2, 6'b000000);
    tick(); ctl("swrdy_m1", 4'd3, 6'b001100);
    tick(); ctl("swrdy_m2", 4'd3, 6'b001100);
    tick(); ctl("swrdy_m3", 4'd3, 6'b001100);
    tick(); busReady = 1'b1; #1;
    ctl("swrdy_m4", 4'd3, 6'b011100);
    tick(); busReady = 1'b0; #1;
    ctl("swrdy_end", 4'd0, 6'b000000);

    // JALR x1,0(x2)
    instrCode = I_JALR;
    tick(); ctl("jalr_d", 4'd1, 6'b000000); dchk("jalr_d", {4'b0000, 1'b1, 3'd4, 3'b011});
    tick(); ctl("jalr_e", 4'd2, 6'b000000);
    tick(); ctl("jalr_wb", 4'd4, 6'b110000);
    tick(); ctl("jalr_end", 4'd0, 6'b000000);

    // Reset asserted in EXECUTE
    instrCode = I_ADD;
    tick(); ctl("rexe_d", 4'd1, 6'b000000);
    tick(); ctl("rexe_e", 4'd2, 6'b000000);
    reset = 1'b1; #1;
    ctl("rexe_rst", 4'd0, 6'b000000); dchk("rexe_rst", 11'd0);
    tick(); reset = 1'b0; #1;
    ctl("rexe_rel", 4'd0, 6'b000000);

    // Reset asserted mid-MEM on a load: no writeback afterwards
    instrCode = I_LW;
    tick(); ctl("rmem_d", 4'd1, 6'b000000);
    tick(); ctl("rmem_e", 4'd2, 6'b000000);
    tick(); ctl("rmem_m1", 4'd3, 6'b001000);
    reset = 1'b1; #1;
    ctl("rmem_rst", 4'd0, 6'b000000); chk("rmem_rst_size", {29'd0, busSize}, 32'd0);
    tick(); reset = 1'b0; instrCode = I_ADD; #1;
    ctl("rmem_rel", 4'd0, 6'b000000);
    tick(); ctl("rmem_add_d", 4'd1, 6'b000000);
    tick(); ctl("rmem_add_e", 4'd2, 6'b000000);
    tick(); ctl("rmem_add_wb", 4'd4, 6'b110000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
